// File: rtl/div_unit_pkg.sv
// Shared encodings for the RV32M divide unit.
//   FUNCT3_* : funct3 field values of the four divide/remainder opcodes
//   FUNCT7_MEXT : funct7 value marking the M extension
//   div_state_e : divider control states
package div_unit_pkg;

    localparam logic [2:0] FUNCT3_DIV  = 3'b100;
    localparam logic [2:0] FUNCT3_DIVU = 3'b101;
    localparam logic [2:0] FUNCT3_REM  = 3'b110;
    localparam logic [2:0] FUNCT3_REMU = 3'b111;

    localparam logic [6:0] FUNCT7_MEXT = 7'b0000001;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/div_unit.sv
// Multi-cycle restoring divider for DIV/DIVU/REM/REMU (one quotient bit per cycle).
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   start           : EX holds a valid divide instruction
//   funct3          : selects DIV/DIVU/REM/REMU
//   op_a, op_b      : dividend, divisor (sampled only when leaving IDLE)
//   stall           : freezes the front end while the divide is in flight
//   done            : one-cycle pulse, result valid
//   result          : registered quotient or remainder
module div_unit
    import div_unit_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            stall,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int unsigned CNT_W   = $clog2(XLEN) + 1;
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [XLEN-1:0]  rem_q, rem_d;
    logic [XLEN-1:0]  quo_q, quo_d;
    logic [XLEN-1:0]  dvs_q, dvs_d;
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
    logic             is_rem_q, is_rem_d;
    logic [XLEN-1:0]  result_q, result_d;

    logic             op_signed, op_rem, a_neg, b_neg, overflow;
    logic [XLEN:0]    rem_sh, trial;
    logic [XLEN-1:0]  rem_step, quo_step;

    assign op_signed = (funct3 == FUNCT3_DIV) || (funct3 == FUNCT3_REM);
    assign op_rem    = (funct3 == FUNCT3_REM) || (funct3 == FUNCT3_REMU);
    assign a_neg     = op_signed && op_a[XLEN-1];
    assign b_neg     = op_signed && op_b[XLEN-1];
    assign overflow  = op_signed && (op_a == MIN_NEG) && (op_b == '1);

    // One restoring step: shift {rem,quo} left, keep the trial difference if it
    // did not borrow. rem < divisor always holds, so XLEN+1 bits cannot overflow.
    always_comb begin
        rem_sh   = {rem_q, quo_q[XLEN-1]};
        trial    = rem_sh - {1'b0, dvs_q};
        rem_step = trial[XLEN] ? rem_sh[XLEN-1:0] : trial[XLEN-1:0];
        quo_step = {quo_q[XLEN-2:0], ~trial[XLEN]};
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvs_d     = dvs_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        is_rem_d  = is_rem_q;
        result_d  = result_q;

        unique case (state_q)
            DIV_IDLE: begin
                if (start) begin
                    is_rem_d = op_rem;
                    if (op_b == '0) begin
                        result_d = op_rem ? op_a : '1;
                        state_d  = DIV_DONE;
                    end else if (overflow) begin
                        result_d = op_rem ? '0 : MIN_NEG;
                        state_d  = DIV_DONE;
                    end else begin
                        quo_d     = a_neg ? -op_a : op_a;
                        dvs_d     = b_neg ? -op_b : op_b;
                        neg_quo_d = a_neg ^ b_neg;
                        neg_rem_d = a_neg;
                        rem_d     = '0;
                        count_d   = CNT_W'(XLEN);
                        state_d   = DIV_BUSY;
                    end
                end
            end
            DIV_BUSY: begin
                rem_d   = rem_step;
                quo_d   = quo_step;
                count_d = count_q - CNT_W'(1);
                if (count_q == CNT_W'(1)) begin
                    // Sign fix-up is applied to this final step's values directly.
                    if (is_rem_q)
                        result_d = neg_rem_q ? -rem_step : rem_step;
                    else
                        result_d = neg_quo_q ? -quo_step : quo_step;
                    state_d = DIV_DONE;
                end
            end
            DIV_DONE: begin
                state_d = DIV_IDLE;
            end
            default: begin
                state_d = DIV_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= DIV_IDLE;
            count_q   <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            is_rem_q  <= 1'b0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvs_q     <= dvs_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            is_rem_q  <= is_rem_d;
            result_q  <= result_d;
        end
    end

    assign stall  = !rst && ((state_q == DIV_IDLE && start) || state_q == DIV_BUSY);
    assign done   = (state_q == DIV_DONE);
    assign result = result_q;

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: driver issues divides and pushes expected
// results/done cycles; a monitor pops and compares on every done pulse.
module tb_div_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        stall;
    logic        done;
    logic [31:0] result;

    int unsigned total = 0;
    int unsigned bad   = 0;
    int unsigned cyc   = 0;
    int unsigned last_done_cyc = 0;
    int unsigned prev_done_cyc = 0;

    typedef struct {
        logic [31:0] res;
        int unsigned done_cyc;
    } exp_t;

    exp_t sb[$];

    div_unit #(.XLEN(32)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .funct3 (funct3),
        .op_a   (op_a),
        .op_b   (op_b),
        .stall  (stall),
        .done   (done),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // Behavioural RV32M reference, straight from the ISA definition.
    function automatic logic [31:0] ref_model(input logic [2:0] f3,
                                              input logic [31:0] a,
                                              input logic [31:0] b);
        if (b == 32'd0)
            return f3[1] ? a : 32'hFFFF_FFFF;
        if (!f3[0]) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
                return f3[1] ? 32'd0 : 32'h8000_0000;
            if (f3[1]) return $signed(a) % $signed(b);
            return $signed(a) / $signed(b);
        end
        return f3[1] ? (a % b) : (a / b);
    endfunction

    function automatic int unsigned ref_latency(input logic [2:0] f3,
                                                input logic [31:0] a,
                                                input logic [31:0] b);
        if (b == 32'd0) return 1;
        if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && done) begin
            prev_done_cyc = last_done_cyc;
            last_done_cyc = cyc;
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got done at cycle %0d expected none", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("result", result, e.res);
                chk("done_cycle", cyc, e.done_cyc);
            end
        end
    end

    // Issue one divide starting just after a posedge; returns after the DONE cycle's posedge.
    task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input bit keep_start, input bit scramble);
        int unsigned lat;
        int unsigned n;
        exp_t e;
        lat = ref_latency(f3, a, b);
        funct3 = f3;
        op_a   = a;
        op_b   = b;
        start  = 1'b1;
        e.res      = ref_model(f3, a, b);
        e.done_cyc = cyc + lat;
        sb.push_back(e);
        n = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!stall) break;
            n++;
            @(posedge clk);
            #1;
            if (scramble && n == 2) begin
                op_a = $urandom;
                op_b = $urandom;
            end
            if (i == 99) begin
                $display("FAIL stall_timeout: got stall stuck high expected release");
                total++;
                bad++;
            end
        end
        chk("stall_len", n, lat);
        @(posedge clk);
        #1;
        if (!keep_start) start = 1'b0;
    endtask

    initial begin
        logic [2:0]  f3;
        logic [31:0] a, b;
        rst = 1'b1; start = 1'b1; funct3 = 3'b101; op_a = 32'd1; op_b = 32'd1;
        repeat (2) begin
            @(negedge clk);
            chk("stall_in_reset", {31'd0, stall}, 32'd0);
        end
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        chk("reset_result", result, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_stall", {31'd0, stall}, 32'd0);
        @(posedge clk); #1;

        // Directed cases
        do_op(3'b101, 32'd100, 32'd7, 0, 1);
        do_op(3'b111, 32'd100, 32'd7, 0, 0);
        do_op(3'b100, 32'hFFFF_FFF9, 32'd2, 0, 1);
        do_op(3'b110, 32'hFFFF_FFF9, 32'd2, 0, 0);
        do_op(3'b101, 32'd5, 32'd0, 0, 0);
        do_op(3'b110, 32'h8000_0005, 32'd0, 0, 0);
        do_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
        do_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
        do_op(3'b100, 32'h8000_0000, 32'd1, 0, 0);
        do_op(3'b111, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);

        // Reset at BUSY iteration 10
        funct3 = 3'b101; op_a = 32'd1000; op_b = 32'd3; start = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1; start = 1'b0;
        @(negedge clk);
        chk("stall_mid_reset", {31'd0, stall}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_reset_stall", {31'd0, stall}, 32'd0);
        chk("post_reset_result", result, 32'd0);
        chk("post_reset_done", {31'd0, done}, 32'd0);
        @(posedge clk); #1;
        do_op(3'b101, 32'd9, 32'd3, 0, 0);

        // Back-to-back with start held high
        do_op(3'b100, 32'd20, 32'd4, 1, 0);
        do_op(3'b100, 32'd21, 32'd4, 0, 0);
        chk("b2b_gap", last_done_cyc - prev_done_cyc, 32'd34);

        // Randomized mix including corner divisors
        for (int i = 0; i < 40; i++) begin
            f3 = {1'b1, 2'($urandom_range(0, 3))};
            a  = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = 32'($urandom_range(1, 15));
                3: b = -32'($urandom_range(1, 15));
                default: b = $urandom;
            endcase
            do_op(f3, a, b, ($urandom_range(0, 1) == 1), ($urandom_range(0, 1) == 1));
        end
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_empty", sb.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
